// File: rtl/alu_rs_scheduler.sv
// alu_rs_scheduler: ALU reservation station with CDB wakeup and lowest-index issue select
module alu_rs_scheduler #(
  parameter int RS_SIZE = 16,
  parameter int TAG_W = 6,
  parameter logic [TAG_W-1:0] TAG_FREE = '1,
  parameter int DATA_W = 32,
  parameter int OP_W = 6,
  parameter int NAME_W = 5,
  parameter int ADDR_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic ALUen,
  input  logic [OP_W-1:0] ALUop,
  input  logic [DATA_W-1:0] ALUoperandO,
  input  logic [DATA_W-1:0] ALUoperandT,
  input  logic [TAG_W-1:0] ALUtagO,
  input  logic [TAG_W-1:0] ALUtagT,
  input  logic [TAG_W-1:0] ALUtagW,
  input  logic [NAME_W-1:0] ALUnameW,
  input  logic [ADDR_W-1:0] ALUaddr,
  input  logic cdbAluEn,
  input  logic [TAG_W-1:0] cdbAluTag,
  input  logic [DATA_W-1:0] cdbAluData,
  input  logic cdbLsEn,
  input  logic [TAG_W-1:0] cdbLsTag,
  input  logic [DATA_W-1:0] cdbLsData,
  output logic [RS_SIZE-1:0] ALUfreeStatus,
  output logic rsFull,
  output logic exEn,
  output logic [OP_W-1:0] exOp,
  output logic [DATA_W-1:0] exOperandO,
  output logic [DATA_W-1:0] exOperandT,
  output logic [TAG_W-1:0] exTagW,
  output logic [NAME_W-1:0] exNameW,
  output logic [ADDR_W-1:0] exAddr
);
  localparam int IDX_W = $clog2(RS_SIZE);
  logic [RS_SIZE-1:0] valid;
  logic [OP_W-1:0] op [RS_SIZE];
  logic [DATA_W-1:0] opnd_o [RS_SIZE];
  logic [DATA_W-1:0] opnd_t [RS_SIZE];
  logic [TAG_W-1:0] tag_o [RS_SIZE];
  logic [TAG_W-1:0] tag_t [RS_SIZE];
  logic [TAG_W-1:0] tag_w [RS_SIZE];
  logic [NAME_W-1:0] name_w [RS_SIZE];
  logic [ADDR_W-1:0] addr [RS_SIZE];
  logic sel_en;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] aidx;
  assign aidx = ALUtagW[IDX_W-1:0];
  assign ALUfreeStatus = ~valid;
  assign rsFull = &valid;
  // A waiting tag becomes free when either bus broadcasts it
  function automatic logic [TAG_W-1:0] wake_tag(input logic [TAG_W-1:0] t);
    return (t != TAG_FREE && ((cdbAluEn && t == cdbAluTag) || (cdbLsEn && t == cdbLsTag))) ? TAG_FREE : t;
  endfunction
  // Captured data; the ALU bus wins if both buses carry the same tag
  function automatic logic [DATA_W-1:0] wake_data(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    return (t == TAG_FREE) ? d : (cdbAluEn && t == cdbAluTag) ? cdbAluData : (cdbLsEn && t == cdbLsTag) ? cdbLsData : d;
  endfunction
  // Lowest-index entry with both operands ready
  always_comb begin
    sel_en = 1'b0;
    sel = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (valid[i] && tag_o[i] == TAG_FREE && tag_t[i] == TAG_FREE) begin
        sel_en = 1'b1;
        sel = IDX_W'(i);
      end
  end
  // Entry allocation, operand wakeup and issue register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= '0;
      exEn <= 1'b0;
      exOp <= '0;
      exOperandO <= '0;
      exOperandT <= '0;
      exTagW <= TAG_FREE;
      exNameW <= '0;
      exAddr <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op[i] <= '0;
        opnd_o[i] <= '0;
        opnd_t[i] <= '0;
        tag_o[i] <= TAG_FREE;
        tag_t[i] <= TAG_FREE;
        tag_w[i] <= TAG_FREE;
        name_w[i] <= '0;
        addr[i] <= '0;
      end
    end else if (clear) begin
      valid <= '0;
      exEn <= 1'b0;
    end else begin
      exEn <= sel_en;
      if (sel_en) begin
        exOp <= op[sel];
        exOperandO <= opnd_o[sel];
        exOperandT <= opnd_t[sel];
        exTagW <= tag_w[sel];
        exNameW <= name_w[sel];
        exAddr <= addr[sel];
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (valid[i]) begin
          tag_o[i] <= wake_tag(tag_o[i]);
          tag_t[i] <= wake_tag(tag_t[i]);
          opnd_o[i] <= wake_data(tag_o[i], opnd_o[i]);
          opnd_t[i] <= wake_data(tag_t[i], opnd_t[i]);
        end
        if (sel_en && sel == IDX_W'(i))
          valid[i] <= 1'b0;
      end
      if (ALUen && !valid[aidx]) begin
        valid[aidx] <= 1'b1;
        op[aidx] <= ALUop;
        tag_o[aidx] <= wake_tag(ALUtagO);
        tag_t[aidx] <= wake_tag(ALUtagT);
        opnd_o[aidx] <= wake_data(ALUtagO, ALUoperandO);
        opnd_t[aidx] <= wake_data(ALUtagT, ALUoperandT);
        tag_w[aidx] <= ALUtagW;
        name_w[aidx] <= ALUnameW;
        addr[aidx] <= ALUaddr;
      end
    end
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// tb_alu_rs_scheduler: scoreboard bench for the ALU reservation station
module tb_alu_rs_scheduler;
  logic clk = 0, rst = 1, clear = 0, ALUen = 0;
  logic [5:0] ALUop = 0;
  logic [31:0] ALUoperandO = 0, ALUoperandT = 0;
  logic [5:0] ALUtagO = 6'h3f, ALUtagT = 6'h3f, ALUtagW = 0;
  logic [4:0] ALUnameW = 0;
  logic [31:0] ALUaddr = 0;
  logic cdbAluEn = 0, cdbLsEn = 0;
  logic [5:0] cdbAluTag = 0, cdbLsTag = 0;
  logic [31:0] cdbAluData = 0, cdbLsData = 0;
  logic [15:0] ALUfreeStatus;
  logic rsFull, exEn;
  logic [5:0] exOp, exTagW;
  logic [31:0] exOperandO, exOperandT, exAddr;
  logic [4:0] exNameW;
  typedef struct {logic [5:0] tw; logic [31:0] o; logic [31:0] t;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;

  alu_rs_scheduler dut (
    .clk(clk), .rst(rst), .clear(clear), .ALUen(ALUen), .ALUop(ALUop),
    .ALUoperandO(ALUoperandO), .ALUoperandT(ALUoperandT), .ALUtagO(ALUtagO), .ALUtagT(ALUtagT),
    .ALUtagW(ALUtagW), .ALUnameW(ALUnameW), .ALUaddr(ALUaddr),
    .cdbAluEn(cdbAluEn), .cdbAluTag(cdbAluTag), .cdbAluData(cdbAluData),
    .cdbLsEn(cdbLsEn), .cdbLsTag(cdbLsTag), .cdbLsData(cdbLsData),
    .ALUfreeStatus(ALUfreeStatus), .rsFull(rsFull), .exEn(exEn), .exOp(exOp),
    .exOperandO(exOperandO), .exOperandT(exOperandT), .exTagW(exTagW),
    .exNameW(exNameW), .exAddr(exAddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [5:0] tw, input logic [5:0] to, input logic [5:0] tt,
                       input logic [31:0] d_o, input logic [31:0] d_t);
    ALUen = 1;
    ALUtagW = tw;
    ALUtagO = to;
    ALUtagT = tt;
    ALUoperandO = d_o;
    ALUoperandT = d_t;
    ALUop = tw + 6'd1;
    ALUnameW = tw[4:0];
    ALUaddr = {26'd0, tw};
  endtask

  // Every issue must match the oldest outstanding expectation
  always @(negedge clk)
    if (exEn) begin
      if (q.size() == 0) chk("unexpected_issue", {58'd0, exTagW}, 64'h3f);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_tagw", exTagW, e.tw);
        chk("sb_opnd_o", exOperandO, e.o);
        chk("sb_opnd_t", exOperandT, e.t);
        chk("sb_op", exOp, e.tw + 6'd1);
      end
    end

  initial begin
    repeat (2) tick;
    rst = 0;
    chk("rst_free", ALUfreeStatus, 16'hffff);
    chk("rst_full", rsFull, 0);
    chk("rst_exen", exEn, 0);
    chk("rst_extagw", exTagW, 6'h3f);
    tick;
    // ready allocation
    alloc(6'd3, 6'h3f, 6'h3f, 5, 7);
    q.push_back('{6'd3, 32'd5, 32'd7});
    tick;
    ALUen = 0;
    chk("ready_free3", ALUfreeStatus[3], 0);
    chk("ready_exen_early", exEn, 0);
    tick;
    chk("ready_exen", exEn, 1);
    chk("ready_opo", exOperandO, 5);
    chk("ready_opt", exOperandT, 7);
    chk("ready_tagw", exTagW, 3);
    chk("ready_free3_back", ALUfreeStatus[3], 1);
    tick;
    chk("ready_pulse", exEn, 0);
    // wakeup from LS bus
    alloc(6'd2, 6'h11, 6'h3f, 0, 8);
    tick;
    ALUen = 0;
    tick;
    tick;
    chk("wait_no_issue", exEn, 0);
    cdbLsEn = 1; cdbLsTag = 6'h11; cdbLsData = 32'hdead;
    q.push_back('{6'd2, 32'hdead, 32'd8});
    tick;
    cdbLsEn = 0;
    chk("wake_exen_early", exEn, 0);
    tick;
    chk("wake_exen", exEn, 1);
    chk("wake_opo", exOperandO, 32'hdead);
    tick;
    // allocation bypass
    alloc(6'd4, 6'h3f, 6'd9, 1, 0);
    cdbAluEn = 1; cdbAluTag = 6'd9; cdbAluData = 42;
    q.push_back('{6'd4, 32'd1, 32'd42});
    tick;
    ALUen = 0; cdbAluEn = 0;
    tick;
    chk("byp_exen", exEn, 1);
    chk("byp_opt", exOperandT, 42);
    tick;
    // both buses wake different operands of one entry
    alloc(6'd6, 6'd12, 6'h13, 0, 0);
    tick;
    ALUen = 0;
    cdbAluEn = 1; cdbAluTag = 6'd12; cdbAluData = 32'haa;
    cdbLsEn = 1; cdbLsTag = 6'h13; cdbLsData = 32'hbb;
    q.push_back('{6'd6, 32'haa, 32'hbb});
    tick;
    cdbAluEn = 0; cdbLsEn = 0;
    tick;
    chk("dual_exen", exEn, 1);
    tick;
    // same tag on both buses: ALU bus wins
    alloc(6'd7, 6'd14, 6'h3f, 0, 3);
    tick;
    ALUen = 0;
    cdbAluEn = 1; cdbAluTag = 6'd14; cdbAluData = 111;
    cdbLsEn = 1; cdbLsTag = 6'd14; cdbLsData = 222;
    q.push_back('{6'd7, 32'd111, 32'd3});
    tick;
    cdbAluEn = 0; cdbLsEn = 0;
    tick;
    tick;
    // fill all entries waiting on LS tag 0x1f, then release them together
    for (int i = 0; i < 16; i++) begin
      alloc(6'(i), 6'h1f, 6'h3f, 0, 32'(i * 3));
      tick;
    end
    ALUen = 0;
    chk("full_rsfull", rsFull, 1);
    chk("full_free", ALUfreeStatus, 16'h0000);
    // allocation into an occupied entry is ignored
    alloc(6'd5, 6'h3f, 6'h3f, 99, 99);
    tick;
    ALUen = 0;
    chk("occupied_no_issue", exEn, 0);
    cdbLsEn = 1; cdbLsTag = 6'h1f; cdbLsData = 77;
    for (int i = 0; i < 16; i++) q.push_back('{6'(i), 32'd77, 32'(i * 3)});
    tick;
    cdbLsEn = 0;
    chk("full_still", rsFull, 1);
    for (int i = 0; i < 16; i++) begin
      tick;
      chk("burst_exen", exEn, 1);
      chk("burst_tagw", exTagW, i);
      if (i == 0) begin
        chk("full_drop", rsFull, 0);
        chk("full_free0", ALUfreeStatus, 16'h0001);
      end
    end
    tick;
    chk("burst_end", exEn, 0);
    chk("burst_free", ALUfreeStatus, 16'hffff);
    // clear discards waiting entries, a pending issue and a simultaneous allocation
    for (int i = 8; i < 12; i++) begin
      alloc(6'(i), 6'h1a, 6'h3f, 0, 0);
      tick;
    end
    alloc(6'd13, 6'h3f, 6'h3f, 1, 1);
    tick;
    clear = 1;
    alloc(6'd12, 6'h3f, 6'h3f, 2, 2);
    tick;
    clear = 0; ALUen = 0;
    chk("clr_free", ALUfreeStatus, 16'hffff);
    chk("clr_exen", exEn, 0);
    tick;
    chk("clr_exen2", exEn, 0);
    cdbLsEn = 1; cdbLsTag = 6'h1a; cdbLsData = 5;
    tick;
    cdbLsEn = 0;
    tick;
    chk("clr_no_issue", exEn, 0);
    tick;
    // asynchronous reset while an issue is pending
    alloc(6'd3, 6'h3f, 6'h3f, 9, 9);
    tick;
    ALUen = 0;
    #2 rst = 1;
    #1;
    chk("arst_free", ALUfreeStatus, 16'hffff);
    chk("arst_exen", exEn, 0);
    chk("arst_tagw", exTagW, 6'h3f);
    tick;
    rst = 0;
    tick;
    chk("arst_no_issue", exEn, 0);
    tick;
    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
